// File: rtl/alu_seq_pkg.sv
// Shared op-code constants and FSM state encoding for the sequential ALU.
// Op codes are common to the combinational ALU and the control decoder.
package alu_seq_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_NOR  = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_MULU = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU core: ADD/SUB/AND/OR/NOR/XOR/SLT.
// MULU and unknown codes give result 0 with no overflow.
module alu_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic             sub;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH-1:0] sum;

    always_comb begin
        // SUB is A + ~B + 1, so one adder serves both.
        sub      = (op == ALU_SUB);
        b_x      = sub ? ~b : b;
        sum      = a + b_x + {{(WIDTH-1){1'b0}}, sub};
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                result   = sum;
                overflow = (a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake on both sides. Single-cycle ops
// finish at the accept edge; MULU runs a shift-add loop, one multiplier bit per cycle.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic               ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

    logic [WIDTH-1:0]   core_res;
    logic               core_ovf;
    logic               accept;

    alu_comb #(.WIDTH(WIDTH)) u_core (
        .op       (op),
        .a        (A),
        .b        (B),
        .result   (core_res),
        .overflow (core_ovf)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result_lo = lo_q;
    assign result_hi = hi_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op == ALU_MULU) begin
                        state_d = ST_MUL;
                        acc_d   = '0;
                        mcand_d = {{WIDTH{1'b0}}, A};
                        mplr_d  = B;
                        cnt_d   = CW'(WIDTH);
                    end else begin
                        state_d = ST_DONE;
                        lo_d    = core_res;
                        hi_d    = '0;
                        ovf_d   = core_ovf;
                        zero_d  = (core_res == '0);
                        neg_d   = core_res[WIDTH-1];
                    end
                end
            end
            ST_MUL: begin
                // Multiplicand shifts left as multiplier bits retire LSB first.
                acc_d   = acc_q + (mplr_q[0] ? mcand_q : '0);
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                    lo_d    = acc_d[WIDTH-1:0];
                    hi_d    = acc_d[2*WIDTH-1:WIDTH];
                    ovf_d   = (acc_d[2*WIDTH-1:WIDTH] != '0);
                    zero_d  = (acc_d == '0);
                    neg_d   = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural model + per-cycle compare against a 32-bit
// instance, directed literal cases, and an 8-bit instance for narrow-width cases.
module tb_alu_seq;

    localparam int W = 32;

    typedef struct packed {
        logic [63:0] prod;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, out_ready, in_ready, out_valid;
    logic [3:0]   op;
    logic [W-1:0] A, B, result_lo, result_hi;
    logic         overflow, zero, negative;

    logic         in_valid8, out_ready8, in_ready8, out_valid8;
    logic [3:0]   op8;
    logic [7:0]   A8, B8, lo8, hi8;
    logic         ovf8, zero8, neg8;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .result_lo(result_lo), .result_hi(result_hi), .overflow(overflow),
        .zero(zero), .negative(negative)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .A(A8), .B(B8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result_lo(lo8), .result_hi(hi8), .overflow(ovf8),
        .zero(zero8), .negative(neg8)
    );

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: straight arithmetic on the operands, 64-bit wide.
    function automatic res_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        longint      sa, sb, s;
        logic [31:0] v;
        r  = '0;
        sa = $signed(a);
        sb = $signed(b);
        s  = 0;
        v  = 32'd0;
        case (o)
            4'd2: begin v = a + b; s = sa + sb; r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd3: begin v = a - b; s = sa - sb; r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd4: v = a & b;
            4'd5: v = a | b;
            4'd6: v = ~(a | b);
            4'd7: v = a ^ b;
            4'd9: v = (sa < sb) ? 32'd1 : 32'd0;
            4'd8: begin
                r.prod = {32'd0, a} * {32'd0, b};
                r.ovf  = (r.prod[63:32] != 32'd0);
                r.zero = (r.prod == 64'd0);
                return r;
            end
            default: v = 32'd0;
        endcase
        r.prod = {32'd0, v};
        r.zero = (v == 32'd0);
        r.neg  = v[31];
        return r;
    endfunction

    // Per-cycle compare: pending transaction, when it becomes visible, what outputs show.
    bit   pending = 1'b0;
    bit   exp_ov;
    int   ready_at = 0;
    res_t exp_r = '0;
    res_t shown = '0;

    always @(negedge clk) begin
        if (reset) begin
            pending = 1'b0;
            shown   = '0;
        end else begin
            exp_ov = pending && (cyc >= ready_at);
            if (exp_ov) shown = exp_r;
            chk("in_ready", {71'd0, in_ready}, {71'd0, !pending});
            chk("out_valid", {71'd0, out_valid}, {71'd0, exp_ov});
            chk("outputs", {5'd0, result_hi, result_lo, overflow, zero, negative}, {5'd0, shown});
            if (!pending && in_valid) begin
                pending  = 1'b1;
                exp_r    = model(op, A, B);
                ready_at = cyc + 1 + ((op == 4'd8) ? W : 0);
            end else if (exp_ov && out_ready) begin
                pending = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 200) begin step(); n++; end
        if (!in_ready) chk("idle_timeout", 72'd0, 72'd1);
    endtask

    // Issue one op with out_ready high; lat = edges from accept edge to out_valid.
    task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output res_t got, output int lat);
        wait_idle();
        op = o; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin step(); lat++; end
        got = {result_hi, result_lo, overflow, zero, negative};
    endtask

    res_t got, snap;
    int   lat;
    logic [31:0] pick [5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; A = '0; B = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = 4'd0; A8 = '0; B8 = '0;
        repeat (2) step();
        chk("reset_state", {64'd0, in_ready, out_valid, overflow, zero, negative, 3'd0},
            {64'd0, 5'b10000, 3'd0});
        chk("reset_result", {8'd0, result_hi, result_lo}, 72'd0);
        reset = 1'b0;
        step();

        // The model itself, pinned by hand-computed values.
        chk("model_add", model(4'd2, 32'h7fffffff, 32'd2), {5'd0, 64'h80000001, 3'b101});
        chk("model_mulu", model(4'd8, 32'hffffffff, 32'hffffffff), {5'd0, 64'hfffffffe00000001, 3'b100});
        chk("model_slt", model(4'd9, 32'hffffffff, 32'd1), {5'd0, 64'd1, 3'b000});
        chk("model_nor", model(4'd6, 32'd17, 32'd356), {5'd0, 64'hfffffe8a, 3'b001});

        run(4'd2, 32'h7fffffff, 32'd2, got, lat);
        chk("add_ovf", got, {5'd0, 64'h80000001, 3'b101});
        chk("add_lat", lat, 1);
        run(4'd3, 32'd7, 32'd7, got, lat);
        chk("sub_zero", got, {5'd0, 64'd0, 3'b010});
        run(4'd8, 32'hffffffff, 32'hffffffff, got, lat);
        chk("mulu_max", got, {5'd0, 64'hfffffffe00000001, 3'b100});
        chk("mulu_lat", lat, W + 1);
        run(4'd8, 32'd3, 32'd5, got, lat);
        chk("mulu_3x5", got, {5'd0, 64'd15, 3'b000});
        run(4'd9, 32'hffffffff, 32'd1, got, lat);
        chk("slt_neg", got, {5'd0, 64'd1, 3'b000});
        run(4'd4, 32'd17, 32'd356, got, lat);
        chk("and", got, {5'd0, 64'd0, 3'b010});
        run(4'd5, 32'd17, 32'd356, got, lat);
        chk("or", got, {5'd0, 64'h175, 3'b000});
        run(4'd6, 32'd17, 32'd356, got, lat);
        chk("nor", got, {5'd0, 64'hfffffe8a, 3'b001});
        run(4'd7, 32'd17, 32'd356, got, lat);
        chk("xor", got, {5'd0, 64'h175, 3'b000});
        run(4'hf, 32'd123, 32'd456, got, lat);
        chk("unknown_op", got, {5'd0, 64'd0, 3'b010});

        // Back-pressure: hold DONE while in_valid stays high with changing operands.
        wait_idle();
        op = 4'd2; A = 32'd8; B = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        step();
        snap = {result_hi, result_lo, overflow, zero, negative};
        chk("bp_first", snap, {5'd0, 64'd12, 3'b000});
        for (int i = 0; i < 5; i++) begin
            A = $urandom; B = $urandom; op = 4'($urandom_range(0, 15));
            step();
            chk("bp_hold", {result_hi, result_lo, overflow, zero, negative}, snap);
            chk("bp_ready", {70'd0, in_ready, out_valid}, {70'd0, 2'b01});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_release", {70'd0, in_ready, out_valid}, {70'd0, 2'b10});
        run(4'd3, 32'd10, 32'd3, got, lat);
        chk("bp_next", got, {5'd0, 64'd7, 3'b000});

        // Asynchronous reset partway through a multiply.
        wait_idle();
        op = 4'd8; A = 32'hdeadbeef; B = 32'h12345678; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        #2 reset = 1'b1;
        #1;
        chk("rst_mid", {8'd0, result_hi, result_lo},  72'd0);
        chk("rst_mid_flags", {67'd0, in_ready, out_valid, overflow, zero, negative}, {67'd0, 5'b10000});
        @(negedge clk);
        step();
        reset = 1'b0;
        run(4'd2, 32'd8, 32'd4, got, lat);
        chk("post_rst_add", got, {5'd0, 64'd12, 3'b000});

        // Random traffic: model-based compare runs every cycle.
        for (int i = 0; i < 3000; i++) begin
            pick[0] = 32'd0; pick[1] = 32'hffffffff; pick[2] = 32'h7fffffff;
            pick[3] = 32'h80000000; pick[4] = $urandom;
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 3) != 0;
            op = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            A  = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
            B  = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (W + 4) step();

        // Narrow instance.
        chk("w8_idle", {71'd0, in_ready8}, {71'd0, 1'b1});
        op8 = 4'd8; A8 = 8'd200; B8 = 8'd200; in_valid8 = 1'b1; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 100) begin step(); lat++; end
        chk("w8_mulu", {55'd0, hi8, lo8, ovf8}, {55'd0, 16'h9c40, 1'b1});
        chk("w8_mulu_lat", lat, 9);
        step();
        op8 = 4'd2; A8 = 8'h80; B8 = 8'h80; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        chk("w8_add", {61'd0, out_valid8, hi8, lo8, ovf8, zero8, neg8}, {61'd0, 1'b1, 16'h0000, 3'b110});
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU, successor to the 32-bit combinational ALU.
- Extends the existing logic/arithmetic ops to WIDTH bits and adds signed set-less-than and an iterative unsigned multiply producing a 2·WIDTH product.
- Wrapped in a valid/ready handshake on both sides, so it can sit as an execute-stage unit that stalls the pipeline while a multiply runs.

## Interface
- WIDTH, 32, operand and result_lo width (≥2)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  unit can accept (high only in IDLE)
- op  in  4  operation code (shared op constants)
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- result_lo  out  WIDTH  result, or low half of product
- result_hi  out  WIDTH  high half of product; 0 for non-MULU ops
- overflow  out  1  signed overflow (ADD/SUB); product-high-nonzero (MULU)
- zero  out  1  full result (hi:lo) == 0
- negative  out  1  result_lo[WIDTH-1]; 0 for MULU

## Operation
- Op codes: 2 ADD, 3 SUB (A−B), 4 AND, 5 OR, 6 NOR, 7 XOR, 8 MULU, 9 SLT (signed A<B → 1, else 0). Any other code gives result 0, zero=1, other flags 0.
- ADD/SUB wrap modulo 2^WIDTH.
  - overflow = operand signs agree (B inverted for SUB) and result sign differs.
  - overflow = 0 for logic ops and SLT.
- MULU: unsigned shift-add, one multiplier bit per cycle, LSB first. Product = {result_hi, result_lo}, exact over 2·WIDTH bits.
- FSM states:
  - IDLE: in_ready=1.
  - MUL: WIDTH iterations remaining, tracked by a counter.
  - DONE: out_valid=1.
- Transitions:
  - IDLE→DONE: accept of a non-MULU op; result and flags registered at the accept edge.
  - IDLE→MUL: accept of MULU; multiplicand, multiplier and counter loaded, accumulator cleared.
  - MUL→DONE: edge that processes the final bit; flags computed from the final product at that edge.
  - DONE→IDLE: out_valid && out_ready.
- Accept = in_valid && in_ready at a rising edge. A, B and op are sampled only at accept. in_valid outside IDLE is ignored and not queued.
- Outputs are held stable from out_valid rise until the handshake completes, and remain at their last values after it until the next completion.

## Timing
- Reset (async, any state, including mid-multiply) gives state IDLE, counter 0, in_ready=1, out_valid=0, result_lo=result_hi=0, overflow=zero=negative=0. Any in-flight op is discarded with no output.
- Non-MULU latency: out_valid high in the cycle directly after the accept edge (1 cycle).
- MULU latency: out_valid high after accept edge + WIDTH edges (WIDTH cycles busy in MUL).
- Minimum issue interval is 2 cycles (accept, then DONE handshake). in_ready is low throughout MUL and DONE.
- out_ready high the first cycle of DONE: returns to IDLE on the next edge; a new accept is possible one edge later.
- Back-pressure: DONE is held indefinitely with outputs unchanged.
- in_ready is a combinational decode of state only. It never depends on in_valid.

## Structure
- Shared header/package: op-code constants (ALU_ADD…ALU_SLT, shared with the existing ALU and control decoder) and FSM state encodings.
- One sub-module: alu_comb, a combinational WIDTH-parametrised core for ADD/SUB/AND/OR/NOR/XOR/SLT with result and overflow outputs. alu_seq adds the FSM, multiply datapath, flag registers and handshake.
- Multiply datapath: 2·WIDTH accumulator, WIDTH multiplier shift register, counter of $clog2(WIDTH+1) bits.

## Test plan
- WIDTH=32, ADD 0x7fffffff+2 → out_valid 1 cycle after accept, result_lo 0x80000001, overflow 1, negative 1, zero 0. Also SUB 7−7 → 0, zero 1.
- WIDTH=32, MULU 0xffffffff×0xffffffff → after exactly 32 busy cycles, hi 0xfffffffe, lo 0x00000001, overflow 1. MULU 3×5 → lo 15, hi 0, overflow 0.
- SLT with A=−1 (0xffffffff), B=1 → 1. Logic ops 17/356 → AND 0, OR 0x175, NOR 0xfffffe8a, XOR 0x175. Unknown op 0xF → 0, zero 1.
- Back-pressure: out_ready held low 5 cycles with in_valid asserted and A/B toggling → outputs stable, in_ready 0, no second accept. out_ready high → IDLE next edge, then new accept.
- Reset asserted mid-MULU (cycle 10 of 32) → all outputs 0 and in_ready 1 immediately without a clock edge. A following ADD 8+4 → 12.
- WIDTH=8: MULU 200×200 → {hi,lo} = 0x9C40 after 8 cycles. ADD 0x80+0x80 → lo 0x00, overflow 1, zero 1.
